// File: rtl/control_pkg.sv
// Shared constants and state type for the 8x8 Game-of-Life controller.
package control_pkg;

    localparam int unsigned GRID_DIM  = 8;
    localparam int unsigned GRID_BITS = GRID_DIM * GRID_DIM;
    localparam int unsigned PAD_DIM   = GRID_DIM + 2;
    localparam int unsigned PAD_BITS  = PAD_DIM * PAD_DIM;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/life_next.sv
// Combinational next-generation logic for an 8x8 Life grid with dead borders.
module life_next
    import control_pkg::*;
(
    input  logic [GRID_BITS-1:0] i_grid,
    output logic [GRID_BITS-1:0] o_next
);

    logic [PAD_BITS-1:0] w_pad;

    // Surround the grid with a ring of permanently dead cells so edges need no special case.
    for (genvar pr = 0; pr < PAD_DIM; pr++) begin : g_pad_row
        if (pr == 0 || pr == PAD_DIM - 1) begin : g_border
            assign w_pad[pr*PAD_DIM +: PAD_DIM] = '0;
        end else begin : g_inner
            assign w_pad[pr*PAD_DIM +: PAD_DIM] =
                {1'b0, i_grid[(pr-1)*GRID_DIM +: GRID_DIM], 1'b0};
        end
    end

    for (genvar r = 0; r < GRID_DIM; r++) begin : g_row
        for (genvar c = 0; c < GRID_DIM; c++) begin : g_col
            localparam int unsigned P = (r + 1) * PAD_DIM + (c + 1);
            logic [CNT_W-1:0] w_cnt;

            assign w_cnt = CNT_W'(w_pad[P-PAD_DIM-1]) + CNT_W'(w_pad[P-PAD_DIM])
                         + CNT_W'(w_pad[P-PAD_DIM+1]) + CNT_W'(w_pad[P-1])
                         + CNT_W'(w_pad[P+1])         + CNT_W'(w_pad[P+PAD_DIM-1])
                         + CNT_W'(w_pad[P+PAD_DIM])   + CNT_W'(w_pad[P+PAD_DIM+1]);

            assign o_next[r*GRID_DIM + c] = (w_cnt == CNT_W'(3)) ||
                                            ((w_cnt == CNT_W'(2)) && i_grid[r*GRID_DIM + c]);
        end
    end

endmodule

// File: rtl/control.sv
// Game-of-Life controller: loads a seed, then steps one generation per clock while start is high.
module control
    import control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [GRID_BITS-1:0] seed,
    input  logic                 start,
    output logic [GRID_BITS-1:0] out_grid
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [GRID_BITS-1:0] r_grid;
    logic [GRID_BITS-1:0] w_grid_nxt;
    logic [GRID_BITS-1:0] w_step;

    life_next u_life_next (
        .i_grid (r_grid),
        .o_next (w_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grid  <= w_grid_nxt;
        end
    end

    // Seed is only looked at on the IDLE->RUN edge; dropping start pauses with the grid held.
    always_comb begin
        w_state_nxt = r_state;
        w_grid_nxt  = r_grid;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_grid_nxt  = seed;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    w_grid_nxt = w_step;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    assign out_grid = r_grid;

endmodule

// File: tb/tb_control.sv
// Directed bench for control: table of per-edge vectors plus async-reset sequences.
module tb_control;

    logic        clk;
    logic        reset;
    logic [63:0] seed;
    logic        start;
    logic [63:0] out_grid;

    int n_chk;
    int n_pass;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [63:0] seed;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    control dut (
        .clk      (clk),
        .reset    (reset),
        .seed     (seed),
        .start    (start),
        .out_grid (out_grid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic [63:0] sd, input logic [63:0] e);
        vec_t v;
        v.rst_n = r;
        v.start = s;
        v.seed  = sd;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: out_grid=%h expected=%h", name, act, exp);
        end
    endtask

    localparam logic [63:0] SEED_A   = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V  = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK    = 64'h0000_0000_0000_0303;
    localparam logic [63:0] LONE     = 64'h0000_0000_0010_0000;
    localparam logic [63:0] TOP3     = 64'h0000_0000_0000_0007;
    localparam logic [63:0] TOP3_N   = 64'h0000_0000_0000_0202;
    localparam logic [63:0] RIGHT3   = 64'h0000_0000_8080_8000;
    localparam logic [63:0] RIGHT3_N = 64'h0000_0000_00C0_0000;
    localparam logic [63:0] JUNK     = 64'hDEAD_BEEF_CAFE_F00D;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        start  = 1'b0;
        seed   = SEED_A;

        #2;
        check("reset_t0", out_grid, 64'h0);

        add(1'b0, 1'b1, SEED_A,  64'h0);
        add(1'b1, 1'b1, SEED_A,  SEED_A);
        add(1'b1, 1'b0, JUNK,    SEED_A);
        add(1'b1, 1'b0, JUNK,    SEED_A);
        add(1'b1, 1'b1, BLINK_H, BLINK_H);
        add(1'b1, 1'b1, JUNK,    BLINK_V);
        add(1'b1, 1'b1, JUNK,    BLINK_H);
        add(1'b1, 1'b1, 64'h0,   BLINK_V);
        add(1'b1, 1'b0, JUNK,    BLINK_V);
        add(1'b1, 1'b0, JUNK,    BLINK_V);
        add(1'b1, 1'b1, BLOCK,   BLOCK);
        add(1'b1, 1'b1, JUNK,    BLOCK);
        add(1'b1, 1'b1, JUNK,    BLOCK);
        add(1'b1, 1'b0, JUNK,    BLOCK);
        add(1'b1, 1'b1, LONE,    LONE);
        add(1'b1, 1'b1, JUNK,    64'h0);
        add(1'b1, 1'b1, JUNK,    64'h0);
        add(1'b1, 1'b0, JUNK,    64'h0);
        add(1'b1, 1'b1, TOP3,    TOP3);
        add(1'b1, 1'b1, JUNK,    TOP3_N);
        add(1'b1, 1'b0, JUNK,    TOP3_N);
        add(1'b1, 1'b1, TOP3,    TOP3);
        add(1'b1, 1'b1, JUNK,    TOP3_N);
        add(1'b1, 1'b1, JUNK,    64'h0);
        add(1'b1, 1'b0, JUNK,    64'h0);
        add(1'b1, 1'b1, RIGHT3,  RIGHT3);
        add(1'b1, 1'b1, JUNK,    RIGHT3_N);
        add(1'b1, 1'b1, JUNK,    64'h0);
        add(1'b1, 1'b0, JUNK,    64'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst_n;
            start = vecs[i].start;
            seed  = vecs[i].seed;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), out_grid, vecs[i].exp);
        end

        // Reset mid-run must clear the grid before the next clock edge.
        @(negedge clk);
        start = 1'b1;
        seed  = BLINK_H;
        @(posedge clk); #1;
        check("mr_load", out_grid, BLINK_H);
        @(posedge clk); #1;
        check("mr_step", out_grid, BLINK_V);
        #2;
        reset = 1'b0;
        #1;
        check("mr_async_clear", out_grid, 64'h0);
        @(posedge clk); #1;
        check("mr_held_in_reset", out_grid, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        seed  = LONE;
        @(posedge clk); #1;
        check("mr_restart_load", out_grid, LONE);
        @(posedge clk); #1;
        check("mr_restart_step", out_grid, 64'h0);

        // Reset pulse shorter than a clock period, applied and released between edges.
        @(negedge clk);
        seed = BLOCK;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        check("pulse_load", out_grid, BLOCK);
        #1 reset = 1'b0;
        #1 check("pulse_clear", out_grid, 64'h0);
        #1 reset = 1'b1;
        seed = TOP3;
        @(posedge clk); #1;
        check("pulse_reload", out_grid, TOP3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
